// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. One 4-bit code per digit slot is presented to a shared hex-to-
// segment decoder together with the matching active-low anode enable. Each
// slot opens with a blanking gap (all anodes off) to suppress ghosting.
// New display values arrive through a valid/ready write port. They are held
// in a pending buffer and copied into the displayed shadow register only at
// a frame boundary, or immediately while the scan is disabled, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS    digits per frame (1..8), digit 0 least significant
//   SLOT_CYCLES   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  blank cycles at the start of each slot (1..SLOT_CYCLES-1)
//
// Ports:
//   iCLK       system clock
//   iRST_N     synchronous active-low reset
//   iEN        scan enable; low keeps the display dark and the scan at start
//   iWR_VALID  write request
//   iWR_DATA   nibble k = code for digit k (4'hF = digit off)
//   oWR_READY  pending buffer empty, a write can be accepted
//   oDIG_CODE  code to the shared decoder; 4'hF whenever no digit is driven
//   oANODE_N   active-low digit enables, at most one bit low
//   oFRAME     one-cycle pulse after each frame boundary
//
// Build option:
//   SEG7_LZB_EN  leading-zero blanking. Digits above the most significant
//                non-zero nibble show 4'hF (anode still driven); digit 0
//                always shows its code.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic                    iEN,
   input  logic                    iWR_VALID,
   input  logic [4*NUM_DIGITS-1:0] iWR_DATA,
   output logic                    oWR_READY,
   output logic [3:0]              oDIG_CODE,
   output logic [NUM_DIGITS-1:0]   oANODE_N,
   output logic                    oFRAME
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [3:0]       CODE_OFF   = 4'hF;

   typedef enum logic {
      ST_BLANK,
      ST_DRIVE
   } scanStateT;

   scanStateT                  state;
   logic [CNT_W-1:0]           slotCnt;
   logic [IDX_W-1:0]           digIdx;
   logic [NUM_DIGITS-1:0][3:0] shadow;    // codes currently displayed
   logic [NUM_DIGITS-1:0][3:0] pending;   // next frame's codes
   logic                       pendFull;

   logic                       blankEnd;
   logic                       slotEnd;
   logic                       frameEnd;
   logic                       writeNow;
   logic                       copyNow;
   logic [NUM_DIGITS-1:0]      driveAnode;
   logic [3:0]                 driveCode;

   assign blankEnd = (state == ST_BLANK) && (slotCnt == BLANK_LAST);
   assign slotEnd  = (state == ST_DRIVE) && (slotCnt == SLOT_LAST);
   assign frameEnd = slotEnd && (digIdx == IDX_LAST);
   assign writeNow = iWR_VALID && oWR_READY;
   // A disabled display has nothing to tear, so pending data is applied at once.
   assign copyNow  = pendFull && (!iEN || frameEnd);

   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      driveAnode         = '1;
      driveAnode[digIdx] = 1'b0;
   end

`ifdef SEG7_LZB_EN
   // lzBlank[k] is set when nibbles k..NUM_DIGITS-1 are all zero; digit 0
   // is never blanked so a zero value still shows a single 0.
   logic [NUM_DIGITS-1:0] lzBlank;

   always_comb begin
      logic zeroAbove;
      zeroAbove = 1'b1;
      lzBlank   = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zeroAbove  = zeroAbove && (shadow[k] == 4'h0);
         lzBlank[k] = zeroAbove;
      end
   end

   assign driveCode = lzBlank[digIdx] ? CODE_OFF : shadow[digIdx];
`else
   assign driveCode = shadow[digIdx];
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state     <= ST_BLANK;
         slotCnt   <= '0;
         digIdx    <= '0;
         oANODE_N  <= '1;
         oDIG_CODE <= CODE_OFF;
         oFRAME    <= 1'b0;
         oWR_READY <= 1'b1;
         // NOTE: the shadow and pending buffers are reset explicitly because
         // a reset must leave the display dark rather than showing stale codes.
         shadow    <= {NUM_DIGITS{CODE_OFF}};
         pending   <= {NUM_DIGITS{CODE_OFF}};
         pendFull  <= 1'b0;
      end else begin
         // Write port. A copy needs a full buffer and a write needs an empty
         // one, so the two never coincide; a write taken in the boundary
         // cycle therefore waits for the following boundary.
         if (copyNow) begin
            shadow    <= pending;
            pendFull  <= 1'b0;
            oWR_READY <= 1'b1;
         end else if (writeNow) begin
            pending   <= iWR_DATA;
            pendFull  <= 1'b1;
            oWR_READY <= 1'b0;
         end

         // Scan sequencer; outputs are registered from the next state.
         if (!iEN) begin
            state     <= ST_BLANK;
            slotCnt   <= '0;
            digIdx    <= '0;
            oFRAME    <= 1'b0;
            oANODE_N  <= '1;
            oDIG_CODE <= CODE_OFF;
         end else begin
            slotCnt <= (slotCnt == SLOT_LAST) ? '0 : slotCnt + 1'b1;
            oFRAME  <= frameEnd;
            if (slotEnd) begin
               state     <= ST_BLANK;
               digIdx    <= (digIdx == IDX_LAST) ? '0 : digIdx + 1'b1;
               oANODE_N  <= '1;
               oDIG_CODE <= CODE_OFF;
            end else if (blankEnd || (state == ST_DRIVE)) begin
               state     <= ST_DRIVE;
               oANODE_N  <= driveAnode;
               oDIG_CODE <= driveCode;
            end else begin
               oANODE_N  <= '1;
               oDIG_CODE <= CODE_OFF;
            end
         end
      end
   end

`ifndef SYNTHESIS
   localparam bit PARAMS_OK = (NUM_DIGITS >= 1) && (NUM_DIGITS <= 8) &&
                              (SLOT_CYCLES >= 2) && (BLANK_CYCLES >= 1) &&
                              (BLANK_CYCLES <= SLOT_CYCLES - 1);

   always_ff @(posedge iCLK) begin
      assert (PARAMS_OK)
         else $error("seg7_scan_ctrl: illegal NUM_DIGITS/SLOT_CYCLES/BLANK_CYCLES");
   end
`endif

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display. All digits share one hex-to-segment decoder. The block sequences one 4-bit code per digit slot into that decoder and drives the matching active-low digit enable. A blanking gap at each slot start suppresses ghosting. New display values enter through a valid/ready write port and take effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, digits scanned per frame (1..8); digit 0 is least significant
SLOT_CYCLES, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (1 .. SLOT_CYCLES-1)

Ports:
iCLK  input  1  system clock
iRST_N  input  1  synchronous active-low reset
iEN  input  1  scan enable; low = display dark, scan held at start
iWR_VALID  input  1  write request
iWR_DATA  input  4*NUM_DIGITS  nibble k = code for digit k (4'hF = digit off)
oWR_READY  output  1  pending buffer empty, write can be accepted
oDIG_CODE  output  4  code to shared decoder; 4'hF whenever no digit is driven
oANODE_N  output  NUM_DIGITS  active-low digit enables; at most one bit low
oFRAME  output  1  one-cycle pulse at each frame boundary

Behaviour:
- All outputs registered. Reset is synchronous, sampled on the iCLK rising edge.
- Reset values:
  - state BLANK, slot counter 0, digit index 0
  - oANODE_N all 1s, oDIG_CODE 4'hF, oFRAME 0, oWR_READY 1
  - shadow register all 4'hF, pending flag 0
- States:
  - BLANK: oANODE_N all 1s, oDIG_CODE 4'hF. Lasts BLANK_CYCLES.
  - DRIVE: oANODE_N[idx]=0, oDIG_CODE = shadow nibble idx. Lasts SLOT_CYCLES-BLANK_CYCLES.
- Slot counter runs 0..SLOT_CYCLES-1 and wraps.
  - BLANK->DRIVE when counter == BLANK_CYCLES-1.
  - DRIVE->BLANK when counter == SLOT_CYCLES-1. idx then increments, wrapping NUM_DIGITS-1 -> 0.
- Registered outputs reflect the new state one cycle after the transition condition.
- Frame boundary: the cycle where DRIVE->BLANK occurs with idx == NUM_DIGITS-1.
  - oFRAME is high in the following cycle.
  - If the pending flag is set, pending is copied to shadow and the flag is cleared at the same edge.
- Write port:
  - Transfer occurs when iWR_VALID && oWR_READY. iWR_DATA is captured into pending, the flag is set, and oWR_READY drops next cycle.
  - While the flag is set, iWR_VALID is ignored and the requester must hold.
  - A write accepted in the frame-boundary cycle lands in pending; it is applied at the next boundary, never the current one.
  - oWR_READY returns to 1 the cycle after the pending-to-shadow copy.
- iEN low:
  - Next cycle: state BLANK, counter 0, idx 0, oFRAME 0.
  - Pending copies to shadow on any cycle where iEN is low and the flag is set, with no frame wait.
  - iEN rising starts a fresh frame at digit 0 with a BLANK gap.
- Reset mid-frame aborts the slot and discards pending data. The display returns dark: shadow all F.
- Counter width is clog2(SLOT_CYCLES). Parameter violations are flagged by a simulation-only check.

Optional Feature:
Macro SEG7_LZB_EN enables leading-zero blanking.
- Defined: during DRIVE, the nibble for digit k is replaced by 4'hF if shadow nibbles k..NUM_DIGITS-1 are all 4'h0 and k != 0. The anode is still driven (dark digit). Digit 0 always shows its code. Blanking logic is combinational on the shadow and registered with oDIG_CODE, adding no latency.
- Undefined: shadow nibbles pass unmodified and no extra logic is synthesized.

Test Plan:
- Reset/idle (NUM_DIGITS=4, SLOT=8, BLANK=2): hold iRST_N=0 for 3 cycles, then release with iEN=0 -> oANODE_N=4'b1111, oDIG_CODE=F, oWR_READY=1, oFRAME=0 on every cycle.
- Scan timing (same params, iEN=1, shadow loaded with 16'h4321 while disabled):
  - Each slot: 2 cycles anodes 1111, then 6 cycles with digit k enabled.
  - Sequence: 1110/code 1, 1101/code 2, 1011/code 3, 0111/code 4.
  - oFRAME pulses once every 32 cycles.
- Frame-synchronous update: write 16'hABCD mid-frame while 16'h4321 is displayed -> oWR_READY=0; remaining slots of the frame still show 4321; after oFRAME, slot 0 shows D; oWR_READY=1 one cycle after the boundary.
- Back-pressure and boundary collision:
  - Second write 16'h1111 held valid while pending is full -> not accepted until ready returns.
  - A write accepted exactly in the boundary cycle appears one frame later, not immediately.
- Enable/reset mid-operation:
  - Drop iEN during slot 2 DRIVE -> next cycle anodes 1111.
  - Re-raise iEN -> 2 blank cycles, then digit 0.
  - Assert iRST_N=0 mid-slot -> shadow all F, display dark after re-enable.
- SEG7_LZB_EN defined, shadow 16'h0050 -> digit 3 and digit 2 driven with code F; digit 1 shows 5, digit 0 shows 0. Shadow 16'h0000 -> only digit 0 shows 0.
